uart_frame_receiver: RTL and testbench

//   UART receive path for the camera board: deserialises 8N1 bytes on i_RX and writes them

---
 rtl/uart_frame_receiver.sv | 159 +++++++++++++++
 tb/tb_uart_frame_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver: 8N1 UART receiver that writes incoming bytes sequentially
// into frame RAM. It flags bad stop bits and abandons a partial frame after a
// long idle gap.
module uart_frame_receiver #(
  parameter int CLKS_PER_BIT    = 1085,
  parameter int BYTES_PER_FRAME = 6144,
  parameter int ADDR_WIDTH      = 15,
  parameter int TIMEOUT_CLKS    = 125000
) (
  input  logic                  Clk,
  input  logic                  i_Reset,
  input  logic                  i_RX,
  input  logic                  i_Enable,
  output logic [7:0]            o_Data,
  output logic [ADDR_WIDTH-1:0] o_Write_Adress,
  output logic                  o_Write_Enable,
  output logic                  o_Frame_Done,
  output logic                  o_Framing_Error,
  output logic                  o_Timeout,
  output logic                  o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0]      C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]      C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]       C_TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_LAST = ADDR_WIDTH'(BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic [ADDR_WIDTH-1:0] r_addr_cnt;
  logic [TO_W-1:0]       r_to_cnt;

  logic w_half_tick;
  logic w_bit_tick;
  logic w_cnt_clear;
  logic w_shift_en;
  logic w_byte_good;
  logic w_frame_err;
  logic w_timeout_hit;
  logic w_last_addr;
  logic w_busy;

  assign w_half_tick = (r_clk_cnt == C_HALF_LAST);
  assign w_bit_tick  = (r_clk_cnt == C_BIT_LAST);

  // Two-flop synchroniser for the asynchronous RX line (idle level is high)
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM next-state logic: start/data/stop sampled at bit centres
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s && i_Enable) w_state_next = S_START;
      S_START: if (w_half_tick) w_state_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_tick && r_bit_cnt == 3'd7) w_state_next = S_STOP;
      S_STOP:  if (w_bit_tick) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM output decode: counter control, sampling strobes and event qualifiers
  always_comb begin
    w_cnt_clear   = (r_state == S_IDLE) || (r_state == S_BREAK) || (w_state_next != r_state);
    w_shift_en    = 1'b0;
    w_byte_good   = 1'b0;
    w_frame_err   = 1'b0;
    w_timeout_hit = 1'b0;
    w_last_addr   = (r_addr_cnt == C_ADDR_LAST);
    w_busy        = (r_state != S_IDLE);
    if (r_state == S_DATA && w_bit_tick) begin
      w_shift_en  = 1'b1;
      w_cnt_clear = 1'b1;
    end
    if (r_state == S_STOP && w_bit_tick) begin
      w_byte_good = r_rx_s;
      w_frame_err = !r_rx_s;
    end
    if (r_state == S_IDLE && r_addr_cnt != '0 && r_to_cnt == C_TO_LAST)
      w_timeout_hit = 1'b1;
  end

  assign o_Busy = w_busy;

  // Baud counter, bit counter and LSB-first shift register
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_clear) r_clk_cnt <= '0;
      else             r_clk_cnt <= r_clk_cnt + 1'b1;
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      else if (w_shift_en)   r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // Idle timer: only counts while idle part-way through a frame
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_to_cnt <= '0;
    end else if (r_state != S_IDLE || r_addr_cnt == '0 || w_timeout_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Write port, address counter and one-cycle event pulses
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Data          <= '0;
      o_Write_Adress  <= '0;
      o_Write_Enable  <= 1'b0;
      o_Frame_Done    <= 1'b0;
      o_Framing_Error <= 1'b0;
      o_Timeout       <= 1'b0;
      r_addr_cnt      <= '0;
    end else begin
      o_Write_Enable  <= w_byte_good;
      o_Frame_Done    <= w_byte_good && w_last_addr;
      o_Framing_Error <= w_frame_err;
      o_Timeout       <= w_timeout_hit;
      if (w_byte_good) begin
        o_Data         <= r_shift;
        o_Write_Adress <= r_addr_cnt;
        r_addr_cnt     <= w_last_addr ? '0 : r_addr_cnt + 1'b1;
      end else if (w_timeout_hit) begin
        r_addr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Testbench for uart_frame_receiver: directed table, hand-written corner
// sequences and randomized bytes checked against a frame-address model.
module tb_uart_frame_receiver;
  localparam int CPB = 16;
  localparam int BPF = 8;
  localparam int AW  = 4;
  localparam int TO  = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          en;
  logic [7:0]    data;
  logic [AW-1:0] addr;
  logic          we, fd, fe, tmo, busy;

  always #5 clk = ~clk;

  uart_frame_receiver #(
    .CLKS_PER_BIT(CPB), .BYTES_PER_FRAME(BPF), .ADDR_WIDTH(AW), .TIMEOUT_CLKS(TO)
  ) dut (
    .Clk(clk), .i_Reset(rst), .i_RX(rx), .i_Enable(en),
    .o_Data(data), .o_Write_Adress(addr), .o_Write_Enable(we),
    .o_Frame_Done(fd), .o_Framing_Error(fe), .o_Timeout(tmo), .o_Busy(busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         en;
    bit         drop_en;
    int         gap;
    bit         exp_wr;
    logic [7:0] exp_data;
    int         exp_addr;
    bit         exp_fd;
    bit         exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         a;
    bit         fd;
  } wr_t;

  int  n_vec = 0;
  int  n_miss = 0;
  int  ferr_cnt = 0;
  int  tmo_cnt = 0;
  int  stray_fd = 0;
  int  m_addr = 0;
  wr_t wq[$];

  // Monitor: record every write strobe and pulse, sampled on the falling edge
  always @(negedge clk) begin : mon
    wr_t w;
    if (we) begin
      w.d  = data;
      w.a  = int'(addr);
      w.fd = fd;
      wq.push_back(w);
    end
    if (fe) ferr_cnt++;
    if (tmo) tmo_cnt++;
    if (fd && !we) stray_fd++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input bit stop, input bit ena,
                              input bit drop, input int gap, input bit ewr,
                              input int eaddr, input bit efd, input bit efe);
    vec_t v;
    v.data = d; v.stop = stop; v.en = ena; v.drop_en = drop; v.gap = gap;
    v.exp_wr = ewr; v.exp_data = d; v.exp_addr = eaddr; v.exp_fd = efd; v.exp_fe = efe;
    return v;
  endfunction

  // Reference model: a good byte lands at the current frame address, the last
  // address of the frame flags frame-done and wraps; a bad stop writes nothing.
  function automatic vec_t model_vec(input logic [7:0] d, input bit stop, input int gap);
    vec_t v;
    v = mk(d, stop, 1'b1, 1'b0, gap, 1'b0, 0, 1'b0, 1'b0);
    if (stop) begin
      v.exp_wr   = 1'b1;
      v.exp_addr = m_addr;
      v.exp_fd   = (m_addr == BPF - 1);
      m_addr     = (m_addr + 1) % BPF;
    end else begin
      v.exp_fe = 1'b1;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int fe_base;
    wq.delete();
    fe_base = ferr_cnt;
    en = v.en;
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) begin
      if (v.drop_en && k == 3) en = 1'b0;
      drive_bit(v.data[k]);
    end
    drive_bit(v.stop);
    check({tag, ".writes"}, wq.size(), int'(v.exp_wr));
    if (v.exp_wr && wq.size() > 0) begin
      check({tag, ".data"}, int'(wq[0].d), int'(v.exp_data));
      check({tag, ".addr"}, wq[0].a, v.exp_addr);
      check({tag, ".frame_done"}, int'(wq[0].fd), int'(v.exp_fd));
    end
    check({tag, ".framing_error"}, ferr_cnt - fe_base, int'(v.exp_fe));
    $display("txn %s: byte=%02h stop=%0d en=%0d writes=%0d", tag, v.data, v.stop, v.en, wq.size());
    rx = 1'b1;
    repeat (v.gap * CPB) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[11];
    vec_t v;
    int   tbase;
    logic [7:0] pb;

    tbl[0]  = mk(8'hA5, 1, 1, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 1);
    tbl[2]  = mk(8'h11, 1, 1, 0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(8'h5A, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(8'hC3, 1, 1, 1, 1, 1, 2, 0, 0);
    tbl[5]  = mk(8'hFF, 1, 1, 0, 0, 1, 3, 0, 0);
    tbl[6]  = mk(8'h00, 1, 1, 0, 0, 1, 4, 0, 0);
    tbl[7]  = mk(8'h80, 1, 1, 0, 2, 1, 5, 0, 0);
    tbl[8]  = mk(8'h01, 1, 1, 0, 0, 1, 6, 0, 0);
    tbl[9]  = mk(8'h7E, 1, 1, 0, 0, 1, 7, 1, 0);
    tbl[10] = mk(8'h42, 1, 1, 0, 1, 1, 0, 0, 0);

    // Reset state
    rst = 1'b1; rx = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.data", int'(data), 0);
    check("reset.addr", int'(addr), 0);
    check("reset.we", int'(we), 0);
    check("reset.frame_done", int'(fd), 0);
    check("reset.framing_error", int'(fe), 0);
    check("reset.timeout", int'(tmo), 0);
    check("reset.busy", int'(busy), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset.busy", int'(busy), 0);

    // Directed table
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));
    m_addr = 1;

    // Randomized bytes against the model
    for (int i = 0; i < 40; i++) begin
      bit bad;
      bad = ($urandom_range(0, 4) == 0);
      v = model_vec(8'($urandom_range(0, 255)), !bad, bad ? 1 : int'($urandom_range(0, 2)));
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of bit 4
    wq.delete();
    pb = 8'h96;
    en = 1'b1;
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(pb[k]);
    rx = pb[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset.busy", int'(busy), 0);
    check("midreset.we", int'(we), 0);
    check("midreset.addr", int'(addr), 0);
    check("midreset.data", int'(data), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("midreset.writes", wq.size(), 0);
    m_addr = 0;

    // Full frame plus one: value = address, frame-done on last, wrap to 0
    for (int i = 0; i <= BPF; i++) begin
      v = model_vec(8'(m_addr), 1'b1, 0);
      run_vec(v, $sformatf("frame%0d", i));
    end

    // Short low glitch: brief busy, then back to idle with no output
    wq.delete();
    tbase = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch.busy_mid", int'(busy), 1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch.busy_after", int'(busy), 0);
    check("glitch.writes", wq.size(), 0);
    check("glitch.framing_error", ferr_cnt - tbase, 0);

    // Mid-frame idle timeout
    for (int i = 0; i < 10; i++) begin
      v = model_vec(8'($urandom_range(0, 255)), 1'b1, 0);
      run_vec(v, $sformatf("pre_to%0d", i));
    end
    tbase = tmo_cnt;
    repeat (TO - 50) @(negedge clk);
    check("timeout.early", tmo_cnt - tbase, 0);
    repeat (2 * TO) @(negedge clk);
    check("timeout.pulses", tmo_cnt - tbase, 1);
    m_addr = 0;
    v = model_vec(8'h5C, 1'b1, 1);
    run_vec(v, "after_timeout");
    check("timeout.total", tmo_cnt - tbase, 1);

    check("stray_frame_done", stray_fd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
